// File: rtl/piradip_axis_pkg.sv
// Shared types and width helpers for the piradip AXI4-Stream FIFO.
package piradip_axis_pkg;

  // Store-and-forward control: HOLD waits for a whole packet, RELEASE streams freely.
  typedef enum logic {
    HOLD    = 1'b0,
    RELEASE = 1'b1
  } axis_fifo_state_t;

  // Packed width of one stored beat: tdata, tkeep, tstrb, tlast, tid, tdest, tuser.
  function automatic int beat_width(input int width, input int id_w,
                                    input int dest_w, input int user_w);
    return width + 2 * (width / 8) + 1 + id_w + dest_w + user_w;
  endfunction

  // Width of a counter that must hold the values 0..depth inclusive.
  function automatic int count_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/piradip_sdp_ram.sv
// Simple dual-port RAM: one synchronous write port, one asynchronous read port.
// The asynchronous read is what gives the FIFO its first-word fall-through.
module piradip_sdp_ram #(
  parameter  int WORD_W = 8,
  parameter  int DEPTH  = 16,
  localparam int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [AW-1:0]     waddr_i,
  input  logic [WORD_W-1:0] wdata_i,
  input  logic [AW-1:0]     raddr_i,
  output logic [WORD_W-1:0] rdata_o
);

  logic [WORD_W-1:0] mem_q [DEPTH];

  // Write port; storage has no reset so it maps onto distributed RAM.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/piradip_axis_fifo.sv
// AXI4-Stream FIFO with first-word fall-through, registered s_tready and an
// optional store-and-forward mode that falls back to streaming when a packet
// is longer than the FIFO.
module piradip_axis_fifo
  import piradip_axis_pkg::*;
#(
  parameter  int WIDTH       = 32,
  parameter  int DEPTH       = 16,
  parameter  int ID_WIDTH    = 1,
  parameter  int DEST_WIDTH  = 1,
  parameter  int USER_WIDTH  = 1,
  parameter  int PACKET_MODE = 0,
  localparam int CW          = count_width(DEPTH)
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic                  s_tvalid,
  output logic                  s_tready,
  input  logic                  s_tlast,
  input  logic [WIDTH-1:0]      s_tdata,
  input  logic [WIDTH/8-1:0]    s_tkeep,
  input  logic [WIDTH/8-1:0]    s_tstrb,
  input  logic [ID_WIDTH-1:0]   s_tid,
  input  logic [DEST_WIDTH-1:0] s_tdest,
  input  logic [USER_WIDTH-1:0] s_tuser,
  output logic                  m_tvalid,
  input  logic                  m_tready,
  output logic                  m_tlast,
  output logic [WIDTH-1:0]      m_tdata,
  output logic [WIDTH/8-1:0]    m_tkeep,
  output logic [WIDTH/8-1:0]    m_tstrb,
  output logic [ID_WIDTH-1:0]   m_tid,
  output logic [DEST_WIDTH-1:0] m_tdest,
  output logic [USER_WIDTH-1:0] m_tuser,
  output logic [CW-1:0]         occupancy,
  output logic [CW-1:0]         pkt_count,
  output logic                  overflow_release
);

  localparam int            AW   = $clog2(DEPTH);
  localparam int            BW   = beat_width(WIDTH, ID_WIDTH, DEST_WIDTH, USER_WIDTH);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    occ_q, occ_d, pkt_q, pkt_d;
  logic             s_tready_q;
  logic             ovf_q, ovf_d;
  axis_fifo_state_t state_q, state_d;
  logic             push, pop, push_last, pop_last;
  logic [BW-1:0]    wr_word, rd_word;

  assign push      = s_tvalid & s_tready_q;
  assign pop       = m_tvalid & m_tready;
  assign push_last = push & s_tlast;
  assign pop_last  = pop & m_tlast;
  assign wr_word   = {s_tdata, s_tkeep, s_tstrb, s_tlast, s_tid, s_tdest, s_tuser};

  piradip_sdp_ram #(
    .WORD_W (BW),
    .DEPTH  (DEPTH)
  ) u_ram (
    .clk     (aclk),
    .we_i    (push),
    .waddr_i (wr_ptr_q),
    .wdata_i (wr_word),
    .raddr_i (rd_ptr_q),
    .rdata_o (rd_word)
  );

  assign {m_tdata, m_tkeep, m_tstrb, m_tlast, m_tid, m_tdest, m_tuser} = rd_word;

  // Pointer and counter updates from this cycle's handshakes; pointers wrap at DEPTH.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    pkt_d    = pkt_q;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    if (push && !pop)      occ_d = occ_q + CW'(1);
    else if (!push && pop) occ_d = occ_q - CW'(1);
    if (push_last && !pop_last)      pkt_d = pkt_q + CW'(1);
    else if (!push_last && pop_last) pkt_d = pkt_q - CW'(1);
  end

  // Store-and-forward FSM; a full FIFO with no complete packet forces RELEASE.
  always_comb begin
    state_d = state_q;
    ovf_d   = 1'b0;
    if (PACKET_MODE != 0) begin
      case (state_q)
        HOLD: begin
          if (occ_q == FULL && pkt_q == '0) begin
            state_d = RELEASE;
            ovf_d   = 1'b1;
          end
        end
        RELEASE: begin
          if (pop_last) state_d = HOLD;
        end
        default: state_d = HOLD;
      endcase
    end
  end

  // Output valid: whole packets only while holding, any stored beat otherwise.
  always_comb begin
    if (PACKET_MODE != 0 && state_q == HOLD) m_tvalid = (pkt_q != '0);
    else                                     m_tvalid = (occ_q != '0);
  end

  // State registers; s_tready is the registered view of "not full".
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      occ_q      <= '0;
      pkt_q      <= '0;
      s_tready_q <= 1'b0;
      ovf_q      <= 1'b0;
      state_q    <= HOLD;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      occ_q      <= occ_d;
      pkt_q      <= pkt_d;
      s_tready_q <= (occ_d < FULL);
      ovf_q      <= ovf_d;
      state_q    <= state_d;
    end
  end

  assign s_tready         = s_tready_q;
  assign occupancy        = occ_q;
  assign pkt_count        = pkt_q;
  assign overflow_release = ovf_q;

endmodule

// File: tb/tb_piradip_axis_fifo.sv
// Bench for piradip_axis_fifo: instance 0 is DEPTH=16 streaming, instance 1 is
// DEPTH=8 packet mode. A queue model checks every cycle; directed literals pin it.
module tb_piradip_axis_fifo;

  typedef logic [43:0] beat_t;
  localparam int LASTB = 3;

  logic aclk = 1'b0;
  logic aresetn = 1'b1;
  logic sv0 = 1'b0, sv1 = 1'b0, mr0 = 1'b0, mr1 = 1'b0;
  beat_t s_beat = '0;

  logic [31:0] s_tdata;
  logic [3:0]  s_tkeep, s_tstrb;
  logic        s_tlast, s_tid, s_tdest, s_tuser;
  assign {s_tdata, s_tkeep, s_tstrb, s_tlast, s_tid, s_tdest, s_tuser} = s_beat;

  logic        s0_tready, m0_tvalid, m0_tlast, m0_tid, m0_tdest, m0_tuser, ovf0;
  logic [31:0] m0_tdata;
  logic [3:0]  m0_tkeep, m0_tstrb;
  logic [4:0]  occ0, pkt0;
  logic        s1_tready, m1_tvalid, m1_tlast, m1_tid, m1_tdest, m1_tuser, ovf1;
  logic [31:0] m1_tdata;
  logic [3:0]  m1_tkeep, m1_tstrb;
  logic [3:0]  occ1, pkt1;

  beat_t m0_beat, m1_beat;
  assign m0_beat = {m0_tdata, m0_tkeep, m0_tstrb, m0_tlast, m0_tid, m0_tdest, m0_tuser};
  assign m1_beat = {m1_tdata, m1_tkeep, m1_tstrb, m1_tlast, m1_tid, m1_tdest, m1_tuser};

  piradip_axis_fifo #(.WIDTH(32), .DEPTH(16), .PACKET_MODE(0)) u_dut0 (
    .aclk(aclk), .aresetn(aresetn),
    .s_tvalid(sv0), .s_tready(s0_tready), .s_tlast(s_tlast), .s_tdata(s_tdata),
    .s_tkeep(s_tkeep), .s_tstrb(s_tstrb), .s_tid(s_tid), .s_tdest(s_tdest), .s_tuser(s_tuser),
    .m_tvalid(m0_tvalid), .m_tready(mr0), .m_tlast(m0_tlast), .m_tdata(m0_tdata),
    .m_tkeep(m0_tkeep), .m_tstrb(m0_tstrb), .m_tid(m0_tid), .m_tdest(m0_tdest), .m_tuser(m0_tuser),
    .occupancy(occ0), .pkt_count(pkt0), .overflow_release(ovf0)
  );

  piradip_axis_fifo #(.WIDTH(32), .DEPTH(8), .PACKET_MODE(1)) u_dut1 (
    .aclk(aclk), .aresetn(aresetn),
    .s_tvalid(sv1), .s_tready(s1_tready), .s_tlast(s_tlast), .s_tdata(s_tdata),
    .s_tkeep(s_tkeep), .s_tstrb(s_tstrb), .s_tid(s_tid), .s_tdest(s_tdest), .s_tuser(s_tuser),
    .m_tvalid(m1_tvalid), .m_tready(mr1), .m_tlast(m1_tlast), .m_tdata(m1_tdata),
    .m_tkeep(m1_tkeep), .m_tstrb(m1_tstrb), .m_tid(m1_tid), .m_tdest(m1_tdest), .m_tuser(m1_tuser),
    .occupancy(occ1), .pkt_count(pkt1), .overflow_release(ovf1)
  );

  always #5 aclk = ~aclk;

  int checks = 0;
  int failures = 0;
  int ovf_seen1 = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  beat_t q0[$], q1[$];
  bit    rdy0, rdy1, rel0, rel1, eovf0, eovf1;

  function automatic int n_lasts(input beat_t q[$]);
    int n = 0;
    foreach (q[i]) if (q[i][LASTB]) n++;
    return n;
  endfunction

  function automatic bit exp_valid(input beat_t q[$], input bit pm, input bit rel);
    if (pm && !rel) return n_lasts(q) > 0;
    return q.size() > 0;
  endfunction

  task automatic model_edge(ref beat_t q[$], input int depth, input bit pm, input logic sv,
                            input beat_t sb, input logic mr, ref bit rdy, ref bit rel,
                            output bit eovf);
    bit push, pop;
    push = (sv === 1'b1) && rdy;
    pop  = exp_valid(q, pm, rel) && (mr === 1'b1);
    eovf = pm && !rel && q.size() == depth && n_lasts(q) == 0;
    if (eovf) rel = 1'b1;
    if (pop) begin
      if (q[0][LASTB]) rel = 1'b0;
      void'(q.pop_front());
    end
    if (push) q.push_back(sb);
    rdy = q.size() < depth;
  endtask

  task automatic cmp(input string t, input beat_t q[$], input bit pm, input bit rel,
                     input bit rdy, input bit eovf, input logic a_rdy, input logic a_vld,
                     input beat_t a_beat, input logic [63:0] a_occ, input logic [63:0] a_pkt,
                     input logic a_ovf);
    bit v;
    v = exp_valid(q, pm, rel);
    check({t, ".s_tready"}, 64'(a_rdy), 64'(rdy));
    check({t, ".m_tvalid"}, 64'(a_vld), 64'(v));
    check({t, ".occupancy"}, a_occ, 64'(q.size()));
    check({t, ".pkt_count"}, a_pkt, 64'(n_lasts(q)));
    check({t, ".overflow_release"}, 64'(a_ovf), 64'(eovf));
    if (v) check({t, ".beat"}, 64'(a_beat), 64'(q[0]));
  endtask

  // Advance the model on each rising edge, then compare once outputs settle.
  always @(posedge aclk) begin
    if (aresetn !== 1'b1) begin
      q0.delete(); q1.delete();
      rdy0 = 0; rdy1 = 0; rel0 = 0; rel1 = 0; eovf0 = 0; eovf1 = 0;
    end else begin
      model_edge(q0, 16, 1'b0, sv0, s_beat, mr0, rdy0, rel0, eovf0);
      model_edge(q1, 8, 1'b1, sv1, s_beat, mr1, rdy1, rel1, eovf1);
    end
    #1;
    cmp("i0", q0, 1'b0, rel0, rdy0, eovf0, s0_tready, m0_tvalid, m0_beat,
        64'(occ0), 64'(pkt0), ovf0);
    cmp("i1", q1, 1'b1, rel1, rdy1, eovf1, s1_tready, m1_tvalid, m1_beat,
        64'(occ1), 64'(pkt1), ovf1);
    if (ovf1 === 1'b1) ovf_seen1++;
  end

  // ---------------- stimulus helpers ----------------
  function automatic beat_t mk(input int n, input bit last);
    logic [31:0] d;
    d = n;
    return {d, 4'hF, d[3:0], last, d[0], d[1], d[2]};
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge aclk);
  endtask

  // Present one beat and hold it until accepted; returns on the negedge after acceptance.
  task automatic push(input int k, input int n, input bit last);
    int w = 0;
    s_beat = mk(n, last);
    if (k == 0) sv0 = 1'b1; else sv1 = 1'b1;
    while (((k == 0) ? s0_tready : s1_tready) !== 1'b1 && w < 200) begin
      @(negedge aclk);
      w++;
    end
    if (w >= 200) begin
      checks++;
      failures++;
      $display("FAIL push_timeout inst=%0d beat=%0d waited=%0d limit=200", k, n, w);
    end
    @(negedge aclk);
    if (k == 0) sv0 = 1'b0; else sv1 = 1'b0;
  endtask

  task automatic drain(input int k);
    int w = 0;
    while (((k == 0) ? m0_tvalid : m1_tvalid) === 1'b1 && w < 200) begin
      @(negedge aclk);
      w++;
    end
    check((k == 0) ? "drain_done0" : "drain_done1", 64'(w < 200), 64'd1);
  endtask

  initial begin
    #1 aresetn = 1'b0;
    tick(1);
    check("rst.s_tready0", 64'(s0_tready), 64'd0);
    check("rst.s_tready1", 64'(s1_tready), 64'd0);
    check("rst.m_tvalid0", 64'(m0_tvalid), 64'd0);
    check("rst.occ0", 64'(occ0), 64'd0);
    check("rst.pkt1", 64'(pkt1), 64'd0);
    check("rst.ovf1", 64'(ovf1), 64'd0);
    aresetn = 1'b1;
    tick(1);
    check("rel.s_tready0", 64'(s0_tready), 64'd1);
    check("rel.s_tready1", 64'(s1_tready), 64'd1);

    // Pass-through: each beat appears one cycle after its push, occupancy stays at 1.
    mr0 = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      push(0, i, 1'b0);
      check("pt.m_tdata", 64'(m0_tdata), 64'(i));
      check("pt.occ", 64'(occ0), 64'd1);
    end
    tick(1);
    check("pt.empty", 64'(m0_tvalid), 64'd0);

    // Fill to 16 under backpressure; beat 117 must wait without being lost.
    mr0 = 1'b0;
    for (int i = 1; i <= 16; i++) push(0, 100 + i, 1'b0);
    check("full.occ", 64'(occ0), 64'd16);
    check("full.s_tready", 64'(s0_tready), 64'd0);
    s_beat = mk(117, 1'b0);
    sv0 = 1'b1;
    tick(3);
    check("full.occ_held", 64'(occ0), 64'd16);
    check("full.head_stable", 64'(m0_tdata), 64'd101);
    mr0 = 1'b1;
    tick(1);
    check("pop1.occ", 64'(occ0), 64'd15);
    check("pop1.s_tready", 64'(s0_tready), 64'd1);
    check("pop1.head", 64'(m0_tdata), 64'd102);
    mr0 = 1'b0;
    tick(1);
    check("refill.occ", 64'(occ0), 64'd16);
    check("refill.s_tready", 64'(s0_tready), 64'd0);
    mr0 = 1'b1;
    for (int i = 18; i <= 20; i++) push(0, 100 + i, 1'b0);
    drain(0);
    check("full.drained", 64'(occ0), 64'd0);

    // Packet mode: nothing leaves until tlast is stored, then 5 contiguous beats.
    mr1 = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      push(1, 200 + i, 1'b0);
      check("pkt.held", 64'(m1_tvalid), 64'd0);
    end
    push(1, 205, 1'b1);
    check("pkt.valid", 64'(m1_tvalid), 64'd1);
    check("pkt.count", 64'(pkt1), 64'd1);
    check("pkt.occ", 64'(occ1), 64'd5);
    for (int j = 1; j <= 5; j++) begin
      check("pkt.stream_valid", 64'(m1_tvalid), 64'd1);
      check("pkt.stream_data", 64'(m1_tdata), 64'(200 + j));
      tick(1);
    end
    check("pkt.done_valid", 64'(m1_tvalid), 64'd0);
    check("pkt.done_count", 64'(pkt1), 64'd0);

    // Fallback: a 12-beat packet in an 8-deep FIFO forces a single release pulse.
    begin
      int base;
      base = ovf_seen1;
      for (int i = 1; i <= 8; i++) push(1, 300 + i, 1'b0);
      check("fb.occ_full", 64'(occ1), 64'd8);
      check("fb.still_held", 64'(m1_tvalid), 64'd0);
      tick(1);
      check("fb.pulse", 64'(ovf1), 64'd1);
      check("fb.released", 64'(m1_tvalid), 64'd1);
      for (int i = 9; i <= 11; i++) push(1, 300 + i, 1'b0);
      push(1, 312, 1'b1);
      drain(1);
      check("fb.pulse_count", 64'(ovf_seen1 - base), 64'd1);
      check("fb.occ_empty", 64'(occ1), 64'd0);
    end
    push(1, 401, 1'b0);
    push(1, 402, 1'b0);
    tick(2);
    check("fb.back_to_hold", 64'(m1_tvalid), 64'd0);
    check("fb.partial_occ", 64'(occ1), 64'd2);

    // Reset in the middle of a packet discards everything.
    mr0 = 1'b0;
    for (int i = 1; i <= 3; i++) push(0, 600 + i, 1'b0);
    for (int i = 3; i <= 6; i++) push(1, 400 + i, 1'b0);
    check("mid.occ1", 64'(occ1), 64'd6);
    check("mid.valid0", 64'(m0_tvalid), 64'd1);
    #2 aresetn = 1'b0;
    #1;
    check("arst.m_tvalid0", 64'(m0_tvalid), 64'd0);
    check("arst.s_tready0", 64'(s0_tready), 64'd0);
    check("arst.s_tready1", 64'(s1_tready), 64'd0);
    check("arst.occ1", 64'(occ1), 64'd0);
    tick(2);
    aresetn = 1'b1;
    tick(1);
    check("post.s_tready1", 64'(s1_tready), 64'd1);
    check("post.pkt1", 64'(pkt1), 64'd0);
    check("post.m_tvalid1", 64'(m1_tvalid), 64'd0);
    mr1 = 1'b1;
    push(1, 501, 1'b0);
    push(1, 502, 1'b0);
    push(1, 503, 1'b1);
    check("post.valid", 64'(m1_tvalid), 64'd1);
    check("post.head", 64'(m1_tdata), 64'd501);
    check("post.occ", 64'(occ1), 64'd3);
    drain(1);
    check("post.drained", 64'(occ1), 64'd0);

    tick(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog time_limit_reached checks=%0d", checks);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/piradip_axis_fifo.md
Name: piradip_axis_fifo

Overview:
- Synchronous AXI4-Stream FIFO with parametrised data width, depth and sideband widths (tkeep, tlast, tid, tdest, tuser).
- Optional packet (store-and-forward) mode.
- Sits between an axi4s MANAGER and an axi4s SUBORDINATE in the same clock domain.
- Used for rate decoupling in front of DMA and radio sample paths; exposes occupancy and complete-packet count to control logic.

Parameters:
- WIDTH, 32: tdata width in bits; multiple of 8.
- DEPTH, 16: FIFO entries; power of two, at least 2.
- ID_WIDTH, 1: tid width. A width of 0 is not supported; use 1 and tie off.
- DEST_WIDTH, 1: tdest width.
- USER_WIDTH, 1: tuser width.
- PACKET_MODE, 0: 1 holds m_tvalid low until a complete packet (tlast) is stored.

Ports:
- aclk  in  1  clock, all logic rising-edge.
- aresetn  in  1  asynchronous active-low reset.
- s_tvalid, s_tready, s_tlast  in/out/in  1  subordinate-side handshake.
- s_tdata  in  WIDTH  input data.
- s_tkeep, s_tstrb  in  WIDTH/8  byte qualifiers.
- s_tid, s_tdest, s_tuser  in  ID_WIDTH/DEST_WIDTH/USER_WIDTH  sideband.
- m_tvalid, m_tready, m_tlast  out/in/out  1  manager-side handshake.
- m_tdata, m_tkeep, m_tstrb, m_tid, m_tdest, m_tuser  out  same widths  output beat.
- occupancy  out  $clog2(DEPTH+1)  stored beats.
- pkt_count  out  $clog2(DEPTH+1)  stored beats carrying tlast.
- overflow_release  out  1  one-cycle pulse when the packet-mode fallback engages.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low (aclk, aresetn).
- Reset values (asserted immediately on aresetn low):
  - s_tready=0, m_tvalid=0, occupancy=0, pkt_count=0, overflow_release=0.
  - Pointers are 0. m_tdata and the other payload outputs are don't-care.
- Reset mid-operation: all stored beats are discarded; no partial beat is presented after release.
- After release, s_tready=1 from the first rising edge of aclk.
- Transfers:
  - Push when s_tvalid and s_tready are both high.
  - Pop when m_tvalid and m_tready are both high.
  - Each beat stores {tdata, tkeep, tstrb, tlast, tid, tdest, tuser} as one word.
- Ready generation:
  - s_tready = (occupancy < DEPTH), registered.
  - s_tready has no combinational dependence on m_tready.
  - When full, a simultaneous pop frees space for the next cycle only.
- Latency:
  - A beat pushed in cycle N is visible on m_* in cycle N+1 (first-word fall-through).
  - Minimum latency is 1 cycle. Throughput is one beat per cycle sustained.
- m_* payload is held stable while m_tvalid=1 and m_tready=0.
- Counters and pointers:
  - Read and write pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.
  - occupancy: +1 on push only, -1 on pop only, unchanged on simultaneous push+pop.
  - pkt_count: +1 on push with tlast, -1 on pop with tlast; push and pop in the same cycle net out.
- PACKET_MODE=0: m_tvalid = (occupancy > 0).
- PACKET_MODE=1, two-state FSM:
  - HOLD: m_tvalid = (pkt_count > 0).
  - HOLD -> RELEASE when occupancy==DEPTH and pkt_count==0. overflow_release pulses for 1 cycle. This fallback prevents deadlock on packets longer than DEPTH.
  - RELEASE: m_tvalid = (occupancy > 0).
  - RELEASE -> HOLD on a pop with m_tlast=1.
  - In HOLD with pkt_count>0, popping proceeds through the packet end exactly as in RELEASE.
- Empty: m_tvalid=0. A pop attempt has no effect; m_tready is ignored.
- Full: s_tready=0. s_tvalid is ignored and no beat is lost.

Decomposition:
- Shared package piradip_axis_pkg:
  - a function giving the packed beat width (WIDTH + 2*WIDTH/8 + 1 + ID_WIDTH + DEST_WIDTH + USER_WIDTH);
  - the enum axis_fifo_state_t {HOLD, RELEASE};
  - a clog2-based count-width helper.
- Sub-module piradip_sdp_ram:
  - simple dual-port, one write and one asynchronous-read port;
  - parametrised by word width and DEPTH;
  - synthesises to distributed RAM.
- The FIFO module owns the pointers, counters, FSM and handshake.

Test Plan:
- Pass-through, DEPTH=16, PACKET_MODE=0, m_tready=1: push 0x1..0x8 back-to-back.
  -> m_tdata 0x1..0x8 on consecutive cycles, each 1 cycle after push; occupancy never exceeds 1.
- Full/backpressure: m_tready=0, push 20 beats.
  -> s_tready drops after beat 16, occupancy=16; raise m_tready -> beats 1..20 out in order, none lost or duplicated.
- Simultaneous push+pop at occupancy=16 with m_tready=1 and s_tvalid=1.
  -> occupancy stays 16 after refill; s_tready tracks occupancy<16 and stays registered.
- Packet mode: push 5-beat packet with tlast on beat 5, m_tready=1.
  -> m_tvalid=0 until the cycle after beat 5 push; pkt_count=1; then 5 beats out contiguously; pkt_count returns to 0.
- Packet fallback: DEPTH=8, push 12-beat packet.
  -> at occupancy=8, overflow_release pulses once; beats stream out; FSM returns to HOLD after tlast pop.
- Reset mid-stream: assert aresetn low with occupancy=6 in the middle of a packet.
  -> m_tvalid and s_tready go 0 immediately; after release, occupancy=0 and pkt_count=0; new packet passes intact.
